// File: rtl/nd_nto1_rr_pkg.sv
// Shared field-size defaults, on/off constants and output FSM encodings for the N-to-1 merger.
// Optional macro NS_NTO1_SRC_TAG_EN is consumed by nd_nto1_rr (source-index tag on the output).
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif
`ifndef NS_NTO1_FSZ
`define NS_NTO1_FSZ 4
`endif
`ifndef NS_2to1_FSZ
`define NS_2to1_FSZ `NS_NTO1_FSZ
`endif

package nd_nto1_rr_pkg;

  localparam logic NS_ON  = 1'b1;
  localparam logic NS_OFF = 1'b0;

  typedef enum logic [1:0] {
    OUT_IDLE = 2'd0,
    OUT_REQ  = 2'd1,
    OUT_WACK = 2'd2
  } out_state_e;

  // Width of an input index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nd_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first pending index at or after ptr, wrapping.
module nd_rr_arbiter
  import nd_nto1_rr_pkg::*;
#(
  parameter  int NUM_IN = 4,
  localparam int IW     = idx_width(NUM_IN)
) (
  input  logic [NUM_IN-1:0] pending,
  input  logic [IW-1:0]     ptr,
  input  logic              enable,
  output logic [NUM_IN-1:0] gnt_onehot,
  output logic [IW-1:0]     gnt_idx,
  output logic              gnt_valid
);

  int          sum_s;
  logic [IW-1:0] cand_s;
  logic        hit_s;

  // Scan candidates in rotated order; the first hit wins and later hits are masked.
  always_comb begin
    gnt_onehot = {NUM_IN{1'b0}};
    gnt_idx    = {IW{1'b0}};
    gnt_valid  = 1'b0;
    sum_s      = 0;
    cand_s     = {IW{1'b0}};
    hit_s      = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      sum_s              = int'(ptr) + k;
      cand_s             = (sum_s >= NUM_IN) ? IW'(sum_s - NUM_IN) : IW'(sum_s);
      hit_s              = enable & ~gnt_valid & pending[cand_s];
      gnt_idx            = hit_s ? cand_s : gnt_idx;
      gnt_onehot[cand_s] = gnt_onehot[cand_s] | hit_s;
      gnt_valid          = gnt_valid | hit_s;
    end
  end

endmodule

// File: rtl/nd_nto1_rr.sv
// N-to-1 4-phase message merger: round-robin input arbitration, FSZ-deep FIFO, one output channel.
// Define NS_NTO1_SRC_TAG_EN to add snd_src, the granted input index carried with each message.
module nd_nto1_rr
  import nd_nto1_rr_pkg::*;
#(
  parameter  int NUM_IN = 4,
  parameter  int FSZ    = `NS_2to1_FSZ,
  parameter  int ASZ    = `NS_ADDRESS_SIZE,
  parameter  int DSZ    = `NS_DATA_SIZE,
  parameter  int RSZ    = `NS_REDUN_SIZE,
  localparam int IW     = idx_width(NUM_IN)
) (
  input  logic                  i_clk,
  input  logic                  reset,
  output logic                  ready,
  input  logic [NUM_IN-1:0]     rcv_req,
  output logic [NUM_IN-1:0]     rcv_ack,
  input  logic [NUM_IN*ASZ-1:0] rcv_addr,
  input  logic [NUM_IN*DSZ-1:0] rcv_data,
  input  logic [NUM_IN*RSZ-1:0] rcv_red,
  output logic                  snd_req,
  input  logic                  snd_ack,
  output logic [ASZ-1:0]        snd_addr,
  output logic [DSZ-1:0]        snd_data,
  output logic [RSZ-1:0]        snd_red
`ifdef NS_NTO1_SRC_TAG_EN
  ,
  output logic [IW-1:0]         snd_src
`endif
);

  localparam int CW = $clog2(FSZ + 1);
  localparam int PW = $clog2(FSZ);
`ifdef NS_NTO1_SRC_TAG_EN
  localparam int EW = IW + ASZ + DSZ + RSZ;
`else
  localparam int EW = ASZ + DSZ + RSZ;
`endif
  localparam logic [CW-1:0] FSZ_C     = CW'(FSZ);
  localparam logic [PW-1:0] LAST_SLOT = PW'(FSZ - 1);
  localparam logic [IW-1:0] LAST_IN   = IW'(NUM_IN - 1);

  logic              ready_r;
  logic [NUM_IN-1:0] rcv_ack_r;
  logic [IW-1:0]     ptr_r;

  logic [EW-1:0]     mem_r [FSZ];
  logic [PW-1:0]     head_r;
  logic [PW-1:0]     tail_r;
  logic [CW-1:0]     count_r;

  out_state_e        state_r;
  out_state_e        state_nxt_s;
  logic              snd_req_r;
  logic              snd_req_nxt_s;
  logic              pop_s;
  logic [ASZ-1:0]    snd_addr_r;
  logic [DSZ-1:0]    snd_data_r;
  logic [RSZ-1:0]    snd_red_r;

  logic [NUM_IN-1:0] pending_s;
  logic [NUM_IN-1:0] gnt_onehot_s;
  logic [IW-1:0]     gnt_idx_s;
  logic              gnt_valid_s;
  logic              fifo_room_s;

  logic [ASZ-1:0]    sel_addr_s;
  logic [DSZ-1:0]    sel_data_s;
  logic [RSZ-1:0]    sel_red_s;
  logic [EW-1:0]     wr_entry_s;
  logic [EW-1:0]     rd_entry_s;
  logic [ASZ-1:0]    rd_addr_s;
  logic [DSZ-1:0]    rd_data_s;
  logic [RSZ-1:0]    rd_red_s;

`ifdef NS_NTO1_SRC_TAG_EN
  logic [IW-1:0]     rd_src_s;
  logic [IW-1:0]     snd_src_r;
`endif

  // A pop in the same cycle does not free a slot for a new grant.
  assign pending_s   = rcv_req & ~rcv_ack_r;
  assign fifo_room_s = (count_r < FSZ_C);

  nd_rr_arbiter #(
    .NUM_IN (NUM_IN)
  ) u_arb (
    .pending    (pending_s),
    .ptr        (ptr_r),
    .enable     (fifo_room_s),
    .gnt_onehot (gnt_onehot_s),
    .gnt_idx    (gnt_idx_s),
    .gnt_valid  (gnt_valid_s)
  );

  // One-hot AND-OR mux of the granted input's fields.
  always_comb begin
    sel_addr_s = {ASZ{1'b0}};
    sel_data_s = {DSZ{1'b0}};
    sel_red_s  = {RSZ{1'b0}};
    for (int i = 0; i < NUM_IN; i++) begin
      sel_addr_s = sel_addr_s | (rcv_addr[i*ASZ +: ASZ] & {ASZ{gnt_onehot_s[i]}});
      sel_data_s = sel_data_s | (rcv_data[i*DSZ +: DSZ] & {DSZ{gnt_onehot_s[i]}});
      sel_red_s  = sel_red_s  | (rcv_red[i*RSZ +: RSZ]  & {RSZ{gnt_onehot_s[i]}});
    end
  end

`ifdef NS_NTO1_SRC_TAG_EN
  assign wr_entry_s = {gnt_idx_s, sel_addr_s, sel_data_s, sel_red_s};
  assign rd_entry_s = mem_r[head_r];
  assign {rd_src_s, rd_addr_s, rd_data_s, rd_red_s} = rd_entry_s;
`else
  assign wr_entry_s = {sel_addr_s, sel_data_s, sel_red_s};
  assign rd_entry_s = mem_r[head_r];
  assign {rd_addr_s, rd_data_s, rd_red_s} = rd_entry_s;
`endif

  // Ready flag, round-robin pointer and per-input acknowledges.
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      ready_r   <= NS_OFF;
      ptr_r     <= {IW{1'b0}};
      rcv_ack_r <= {NUM_IN{1'b0}};
    end else begin
      ready_r <= NS_ON;
      if (gnt_valid_s) begin
        ptr_r <= (gnt_idx_s == LAST_IN) ? {IW{1'b0}} : gnt_idx_s + IW'(1);
      end
      for (int i = 0; i < NUM_IN; i++) begin
        if (gnt_onehot_s[i]) begin
          rcv_ack_r[i] <= 1'b1;
        end else if (!rcv_req[i]) begin
          rcv_ack_r[i] <= 1'b0;
        end
      end
    end
  end

  // Message FIFO; head/tail wrap at FSZ, which need not be a power of two.
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FSZ; i++) begin
        mem_r[i] <= {EW{1'b0}};
      end
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (gnt_valid_s) begin
        mem_r[tail_r] <= wr_entry_s;
        tail_r        <= (tail_r == LAST_SLOT) ? {PW{1'b0}} : tail_r + PW'(1);
      end
      if (pop_s) begin
        head_r <= (head_r == LAST_SLOT) ? {PW{1'b0}} : head_r + PW'(1);
      end
      case ({gnt_valid_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Output FSM next-state: load from the FIFO in IDLE, then run the 4-phase handshake.
  always_comb begin
    state_nxt_s   = state_r;
    snd_req_nxt_s = snd_req_r;
    pop_s         = 1'b0;
    case (state_r)
      OUT_IDLE: begin
        if (count_r != {CW{1'b0}}) begin
          pop_s         = 1'b1;
          snd_req_nxt_s = 1'b1;
          state_nxt_s   = OUT_REQ;
        end else begin
          state_nxt_s   = OUT_IDLE;
        end
      end
      OUT_REQ: begin
        if (snd_ack) begin
          snd_req_nxt_s = 1'b0;
          state_nxt_s   = OUT_WACK;
        end else begin
          state_nxt_s   = OUT_REQ;
        end
      end
      OUT_WACK: begin
        if (!snd_ack) begin
          state_nxt_s = OUT_IDLE;
        end else begin
          state_nxt_s = OUT_WACK;
        end
      end
      default: begin
        state_nxt_s   = OUT_IDLE;
        snd_req_nxt_s = 1'b0;
      end
    endcase
  end

  // Output FSM state and registered snd_* fields, held stable while snd_req is high.
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      state_r    <= OUT_IDLE;
      snd_req_r  <= 1'b0;
      snd_addr_r <= {ASZ{1'b0}};
      snd_data_r <= {DSZ{1'b0}};
      snd_red_r  <= {RSZ{1'b0}};
`ifdef NS_NTO1_SRC_TAG_EN
      snd_src_r  <= {IW{1'b0}};
`endif
    end else begin
      state_r   <= state_nxt_s;
      snd_req_r <= snd_req_nxt_s;
      if (pop_s) begin
        snd_addr_r <= rd_addr_s;
        snd_data_r <= rd_data_s;
        snd_red_r  <= rd_red_s;
`ifdef NS_NTO1_SRC_TAG_EN
        snd_src_r  <= rd_src_s;
`endif
      end
    end
  end

  assign ready    = ready_r;
  assign rcv_ack  = rcv_ack_r;
  assign snd_req  = snd_req_r;
  assign snd_addr = snd_addr_r;
  assign snd_data = snd_data_r;
  assign snd_red  = snd_red_r;
`ifdef NS_NTO1_SRC_TAG_EN
  assign snd_src  = snd_src_r;
`endif

endmodule

// File: tb/tb_nd_nto1_rr.sv
// Scoreboard bench for nd_nto1_rr: queue-based reference model, randomized 4-phase producers/consumer.
module tb_nd_nto1_rr;
  localparam int NUM_IN = 4;
  localparam int FSZ    = 3;
  localparam int ASZ    = 8;
  localparam int DSZ    = 8;
  localparam int RSZ    = 4;
  localparam int IW     = 2;

  logic                  i_clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  ready;
  logic [NUM_IN-1:0]     rcv_req = '0;
  logic [NUM_IN-1:0]     rcv_ack;
  logic [NUM_IN*ASZ-1:0] rcv_addr = '0;
  logic [NUM_IN*DSZ-1:0] rcv_data = '0;
  logic [NUM_IN*RSZ-1:0] rcv_red = '0;
  logic                  snd_req;
  logic                  snd_ack = 1'b0;
  logic [ASZ-1:0]        snd_addr;
  logic [DSZ-1:0]        snd_data;
  logic [RSZ-1:0]        snd_red;
`ifdef NS_NTO1_SRC_TAG_EN
  logic [IW-1:0]         snd_src;
`endif

  always #5 i_clk = ~i_clk;

  nd_nto1_rr #(.NUM_IN(NUM_IN), .FSZ(FSZ), .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_dut (
    .i_clk(i_clk), .reset(reset), .ready(ready),
    .rcv_req(rcv_req), .rcv_ack(rcv_ack), .rcv_addr(rcv_addr), .rcv_data(rcv_data), .rcv_red(rcv_red),
    .snd_req(snd_req), .snd_ack(snd_ack), .snd_addr(snd_addr), .snd_data(snd_data), .snd_red(snd_red)
`ifdef NS_NTO1_SRC_TAG_EN
    , .snd_src(snd_src)
`endif
  );

  typedef struct packed {
    logic [IW-1:0]  src;
    logic [ASZ-1:0] addr;
    logic [DSZ-1:0] data;
    logic [RSZ-1:0] red;
  } msg_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, round-robin rule evaluated directly.
  msg_t              m_buf[$];
  msg_t              exp_q[$];
  logic [NUM_IN-1:0] m_ack = '0;
  int                m_ptr = 0;
  int                m_state = 0;
  logic              m_snd_req = 1'b0;

  always @(posedge i_clk or negedge reset) begin : model_step
    int   g;
    int   old_cnt;
    int   cand;
    msg_t mm;
    if (!reset) begin
      m_buf.delete();
      exp_q.delete();
      m_ack     = '0;
      m_ptr     = 0;
      m_state   = 0;
      m_snd_req = 1'b0;
    end else begin
      g       = -1;
      old_cnt = m_buf.size();
      if (old_cnt < FSZ) begin
        for (int k = 0; k < NUM_IN; k++) begin
          cand = (m_ptr + k) % NUM_IN;
          if (g < 0 && rcv_req[cand] && !m_ack[cand]) g = cand;
        end
      end
      case (m_state)
        0: if (old_cnt > 0) begin exp_q.push_back(m_buf.pop_front()); m_snd_req = 1'b1; m_state = 1; end
        1: if (snd_ack) begin m_snd_req = 1'b0; m_state = 2; end
        2: if (!snd_ack) m_state = 0;
        default: m_state = 0;
      endcase
      if (g >= 0) begin
        mm.src  = IW'(g);
        mm.addr = rcv_addr[g*ASZ +: ASZ];
        mm.data = rcv_data[g*DSZ +: DSZ];
        mm.red  = rcv_red[g*RSZ +: RSZ];
        m_buf.push_back(mm);
        m_ptr = (g + 1) % NUM_IN;
      end
      for (int i = 0; i < NUM_IN; i++) begin
        if (i == g) m_ack[i] = 1'b1;
        else if (!rcv_req[i]) m_ack[i] = 1'b0;
      end
    end
  end

  // Monitor: pop the scoreboard on every new snd_req and compare fields.
  logic [ASZ-1:0]    obs_addr[$];
  logic [IW-1:0]     obs_src[$];
  logic              prev_req = 1'b0;
  logic [NUM_IN-1:0] prev_ack = '0;
  int                ack_rises = 0;
  msg_t              e;

  always @(negedge i_clk) begin
    if (!reset) begin
      prev_req = 1'b0;
      prev_ack = '0;
    end else begin
      if (snd_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_req", 32'(snd_req), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("sb_addr", 32'(snd_addr), 32'(e.addr));
          chk("sb_data", 32'(snd_data), 32'(e.data));
          chk("sb_red", 32'(snd_red), 32'(e.red));
`ifdef NS_NTO1_SRC_TAG_EN
          chk("sb_src", 32'(snd_src), 32'(e.src));
          obs_src.push_back(snd_src);
`endif
          obs_addr.push_back(snd_addr);
        end
      end
      for (int i = 0; i < NUM_IN; i++) if (rcv_ack[i] && !prev_ack[i]) ack_rises++;
      prev_req = snd_req;
      prev_ack = rcv_ack;
      chk("cyc_rcv_ack", 32'(rcv_ack), 32'(m_ack));
      chk("cyc_snd_req", 32'(snd_req), 32'(m_snd_req));
      chk("cyc_count", 32'(u_dut.count_r), 32'(m_buf.size()));
    end
  end

  // Stimulus state for the per-input producers and the output consumer.
  int drv_st[NUM_IN];
  int quota[NUM_IN];
  int gap[NUM_IN];
  int max_gap = 0;
  bit fair_mode = 1'b0;
  bit ack_hold = 1'b0;
  bit ack_rand = 1'b0;

  task automatic drive_cycle();
    logic [31:0] rnd;
    for (int i = 0; i < NUM_IN; i++) begin
      if (drv_st[i] == 1) begin
        if (rcv_ack[i]) begin rcv_req[i] = 1'b0; drv_st[i] = 2; end
      end else if (drv_st[i] == 2) begin
        if (!rcv_ack[i]) begin
          drv_st[i] = 0;
          gap[i] = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        end
      end
      if (drv_st[i] == 0 && quota[i] > 0) begin
        if (gap[i] > 0) gap[i]--;
        else begin
          rnd = $urandom;
          rcv_addr[i*ASZ +: ASZ] = fair_mode ? ASZ'(i) : rnd[7:0];
          rcv_data[i*DSZ +: DSZ] = rnd[15:8];
          rcv_red[i*RSZ +: RSZ]  = rnd[19:16];
          rcv_req[i] = 1'b1;
          quota[i]--;
          drv_st[i] = 1;
        end
      end
    end
    if (ack_hold) snd_ack = 1'b0;
    else if (snd_req && !snd_ack) begin
      if (!ack_rand || $urandom_range(2, 0) == 0) snd_ack = 1'b1;
    end else if (!snd_req && snd_ack) begin
      if (!ack_rand || $urandom_range(1, 0) == 0) snd_ack = 1'b0;
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge i_clk); #1;
      drive_cycle();
    end
  endtask

  function automatic bit all_idle();
    bit idle;
    idle = (m_buf.size() == 0) && (exp_q.size() == 0) && (m_state == 0) && !snd_req && !snd_ack;
    for (int i = 0; i < NUM_IN; i++) idle = idle && (drv_st[i] == 0) && (quota[i] == 0);
    return idle;
  endfunction

  task automatic run_until_idle(input string name, input int budget);
    int c;
    c = 0;
    while (!all_idle() && c < budget) begin
      run_cycles(1);
      c++;
    end
    chk({name, "_timeout"}, 32'(all_idle()), 32'(1));
  endtask

  task automatic clear_bench();
    rcv_req = '0;
    snd_ack = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin drv_st[i] = 0; quota[i] = 0; gap[i] = 0; end
    max_gap = 0; fair_mode = 1'b0; ack_hold = 1'b0; ack_rand = 1'b0;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    obs_addr.delete();
    obs_src.delete();
    ack_rises = 0;
    reset = 1'b1;
    @(posedge i_clk); #1;
    chk("ready_after_release", 32'(ready), 32'(1));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_bench();
    release_reset();
  endtask

  initial begin
    int total;
    clear_bench();
    #2;
    chk("rst_ready", 32'(ready), 32'(0));
    chk("rst_snd_req", 32'(snd_req), 32'(0));
    chk("rst_rcv_ack", 32'(rcv_ack), 32'(0));
    chk("rst_snd_fields", 32'({snd_addr, snd_data, snd_red}), 32'(0));
    release_reset();

    // Single message from input 2 with the documented latency.
    rcv_addr[2*ASZ +: ASZ] = 8'h05;
    rcv_data[2*DSZ +: DSZ] = 8'hA5;
    rcv_red[2*RSZ +: RSZ]  = 4'h3;
    rcv_req[2] = 1'b1;
    @(posedge i_clk); #1;
    chk("single_ack_c1", 32'(rcv_ack), 32'(4'b0100));
    chk("single_req_c1", 32'(snd_req), 32'(0));
    rcv_req[2] = 1'b0;
    @(posedge i_clk); #1;
    chk("single_req_c2", 32'(snd_req), 32'(1));
    chk("single_addr", 32'(snd_addr), 32'(8'h05));
    chk("single_data", 32'(snd_data), 32'(8'hA5));
    chk("single_ack_low", 32'(rcv_ack), 32'(0));
    snd_ack = 1'b1;
    @(posedge i_clk); #1;
    chk("single_req_drop", 32'(snd_req), 32'(0));
    snd_ack = 1'b0;
    run_cycles(3);

    // Fairness: all inputs keep requesting; sources must come out 0,1,2,3,0,1,2,3.
    do_reset();
    fair_mode = 1'b1;
    for (int i = 0; i < NUM_IN; i++) quota[i] = 2;
    run_until_idle("fair", 400);
    chk("fair_count", 32'(obs_addr.size()), 32'(8));
    for (int k = 0; k < 8 && k < obs_addr.size(); k++) chk("fair_order", 32'(obs_addr[k]), 32'(k % NUM_IN));

    // Full FIFO with snd_ack held low: FSZ buffered plus one in the output register.
    do_reset();
    ack_hold = 1'b1;
    quota[0] = 2; quota[1] = 2; quota[2] = 1; quota[3] = 1;
    run_cycles(20);
    chk("full_acks", 32'(ack_rises), 32'(FSZ + 1));
    chk("full_snd_req", 32'(snd_req), 32'(1));
    chk("full_count", 32'(u_dut.count_r), 32'(FSZ));
    ack_hold = 1'b0;
    run_until_idle("full_drain", 500);
    chk("full_total_acks", 32'(ack_rises), 32'(6));
    chk("full_total_msgs", 32'(obs_addr.size()), 32'(6));

    // Randomized traffic wrapping the non-power-of-two FIFO several times.
    do_reset();
    max_gap = 3;
    ack_rand = 1'b1;
    total = 0;
    for (int i = 0; i < NUM_IN; i++) begin quota[i] = int'($urandom_range(5, 3)); total += quota[i]; end
    run_until_idle("rand", 3000);
    chk("rand_msgs", 32'(obs_addr.size()), 32'(total));

    // Reset asserted mid-REQ with FSZ messages buffered.
    do_reset();
    ack_hold = 1'b1;
    for (int i = 0; i < NUM_IN; i++) quota[i] = 1;
    run_cycles(12);
    chk("midrst_pre_count", 32'(u_dut.count_r), 32'(FSZ));
    chk("midrst_pre_req", 32'(snd_req), 32'(1));
    #3;
    reset = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready), 32'(0));
    chk("midrst_snd_req", 32'(snd_req), 32'(0));
    chk("midrst_rcv_ack", 32'(rcv_ack), 32'(0));
    chk("midrst_fields", 32'({snd_addr, snd_data, snd_red}), 32'(0));
    clear_bench();
    release_reset();
    chk("midrst_post_count", 32'(u_dut.count_r), 32'(0));
    chk("midrst_post_req", 32'(snd_req), 32'(0));
    quota[1] = 1;
    run_until_idle("midrst_new", 200);
    chk("midrst_new_msgs", 32'(obs_addr.size()), 32'(1));

`ifdef NS_NTO1_SRC_TAG_EN
    // Source tag: input 3 then input 1.
    do_reset();
    quota[3] = 1;
    run_until_idle("tag_a", 200);
    quota[1] = 1;
    run_until_idle("tag_b", 200);
    chk("tag_count", 32'(obs_src.size()), 32'(2));
    if (obs_src.size() == 2) begin
      chk("tag_first", 32'(obs_src[0]), 32'(3));
      chk("tag_second", 32'(obs_src[1]), 32'(1));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/nd_nto1_rr.md
Name: nd_nto1_rr

Overview:
- Parametrised N-to-1 message merger; successor to the fixed 2-input merger.
- Accepts messages (address/data/redundancy) from NUM_IN 4-phase req/ack input channels.
- Arbitrates among them with a fair round-robin pointer, buffers messages in a FSZ-deep FIFO, and drives one 4-phase output channel.
- Sits at network-node fan-in points: many cell ports feed one link.

Parameters:
- NUM_IN, 4, number of input channels (>=2).
- FSZ, `NS_2to1_FSZ, FIFO depth in messages (>=2, any integer).
- ASZ, `NS_ADDRESS_SIZE, address field width.
- DSZ, `NS_DATA_SIZE, data field width.
- RSZ, `NS_REDUN_SIZE, redundancy field width.

Ports:
- i_clk  in  1  single clock, all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- ready  out  1  block initialised and operating.
- rcv_req  in  NUM_IN  per-input request.
- rcv_ack  out  NUM_IN  per-input acknowledge.
- rcv_addr  in  NUM_IN*ASZ  packed addresses; input i at [i*ASZ +: ASZ].
- rcv_data  in  NUM_IN*DSZ  packed data.
- rcv_red  in  NUM_IN*RSZ  packed redundancy.
- snd_req  out  1  output request.
- snd_ack  in  1  output acknowledge.
- snd_addr  out  ASZ  output address.
- snd_data  out  DSZ  output data.
- snd_red  out  RSZ  output redundancy.

Behaviour:
- Reset (reset==0, async): all outputs 0, ready=0, FIFO empty, rr pointer=0, output FSM IDLE, all rcv_ack=0.
- Reset release: ready=1 on first posedge after release. Input/output activity starts on the same edge.
- rcv_req and snd_ack are synchronous to i_clk. No internal synchronisers.
- Input i is pending when rcv_req[i]=1 and rcv_ack[i]=0.
- Arbitration: grant the first pending index at or after ptr, wrapping modulo NUM_IN.
  - Only when FIFO count < FSZ; no same-cycle pop credit.
  - At most one grant per cycle.
  - On grant g: write input g's fields at the tail, set rcv_ack[g]=1 next cycle, set ptr to (g+1) mod NUM_IN.
  - Without a grant, ptr holds.
- Input release: rcv_ack[i] clears on the cycle after rcv_req[i] is seen low. It stays high while rcv_req[i] stays high.
- Full: pending inputs wait with ack low. No drop, no reorder within an input.
- Output FSM:
  - IDLE: if FIFO non-empty, load head into the snd_* registers, pop, set snd_req=1, go to REQ.
  - REQ: snd_* stable; on snd_ack=1, clear snd_req and go to WACK.
  - WACK: on snd_ack=0, go to IDLE.
- Latency: rcv_req[i] rises at cycle 0 with the FIFO empty and the output idle:
  - rcv_ack[i]=1 at cycle 1;
  - snd_req=1 at cycle 2.
- Simultaneous push and pop: count unchanged. Head/tail pointers wrap at FSZ (modulo, non-power-of-two legal).
- Count width: $clog2(FSZ+1).
- Reset mid-handshake: everything aborts; buffered messages are lost; acks drop immediately.

Optional Feature:
- Macro: NS_NTO1_SRC_TAG_EN.
- Defined:
  - adds output port snd_src, width max(1,$clog2(NUM_IN)), carrying the granted input index;
  - the FIFO entry is widened to hold the index;
  - snd_src is valid and stable while snd_req=1, and resets to 0.
- Undefined: port absent, FIFO entry = ASZ+DSZ+RSZ bits; behaviour otherwise identical.

Decomposition:
- Shared package (hglobal.v defines): NS_ON/NS_OFF, field-size defaults, `NS_NTO1_FSZ default, output FSM state encodings (IDLE=0, REQ=1, WACK=2).
- One sub-module: nd_rr_arbiter.
  - Parametrised by NUM_IN.
  - Inputs: pending vector, ptr, enable.
  - Outputs: grant one-hot, grant index, grant valid.
  - Purely combinational; ptr register stays in the parent.

Test Plan:
- Single message: input 2 sends addr=5, data=0xA5 -> rcv_ack[2] at cycle 1; snd_req at cycle 2 with addr=5, data=0xA5; ack/req 4-phase completes.
- Fairness: all 4 inputs request continuously, each refiring after ack drops -> output source order 0,1,2,3,0,1,2,3 over 8 messages; no input starves.
- Full FIFO (FSZ=4): snd_ack held 0, 6 distinct requests -> exactly 5 acks (1 in output register + 4 buffered). The 6th is acked only after the first output handshake completes. Output order matches grant order.
- Simultaneous push and pop at count=2 -> count stays 2; no data corruption across a 10-message wrap-around (FSZ=3 run covers non-power-of-two).
- Async reset asserted mid-REQ with 3 buffered messages -> all outputs 0 within the same cycle. After release: ready=1, FIFO empty, first new message appears unaltered.
- NS_NTO1_SRC_TAG_EN defined: messages from inputs 3 and 1 -> snd_src=3 then 1, matching data.
